teclado_clave: RTL and testbench
================================

TECLADO_CLAVE -- requirements
Module: teclado_clave

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles between keys before the entry is aborted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe that a key was pressed.
REQ-005 The block SHALL have port key_code, input, 4 bits: 0-9 are digits, 4'hA is CLEAR, 4'hB is ENTER, and 4'hC-4'hF are ignored.
REQ-006 The block SHALL have port sensor_vehicule, input, 1 bit: a vehicle is present, which enables entry.
REQ-007 The block SHALL have port alarm_blocked, input, 1 bit: the controller is blocked, which locks the keypad.
REQ-008 The block SHALL have port password_input, output, 16 bits: four BCD digits, first-typed digit in [15:12].
REQ-009 The block SHALL have port password_valid, output, 1 bit: one-cycle pulse that password_input is complete.
REQ-010 The block SHALL have port entry_error, output, 1 bit: one-cycle pulse on a short ENTER or a timeout.
REQ-011 The block SHALL have port digit_count, output, 3 bits: number of digits buffered, 0 to 4.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, COLLECT, PRESENT and LOCKED.
REQ-013 In IDLE, a digit key with sensor_vehicule=1 SHALL load that digit, set digit_count=1 and move to COLLECT.
REQ-014 In IDLE, any key while sensor_vehicule=0 SHALL be ignored, and a non-digit key SHALL be ignored.
REQ-015 In COLLECT, a digit with digit_count<4 SHALL shift in as {buf[11:0],digit} and increment digit_count.
REQ-016 In COLLECT, digits arriving when digit_count=4 SHALL be ignored.
REQ-017 In COLLECT, CLEAR SHALL zero the buffer and digit_count and return to IDLE with no pulse.
REQ-018 ENTER with digit_count=4 SHALL drive password_input=buf and pulse password_valid in the next cycle, then go to PRESENT.
REQ-019 ENTER with digit_count<4 SHALL pulse entry_error, clear the buffer and return to IDLE.
REQ-020 An inactivity counter SHALL reset on every accepted key in COLLECT.
REQ-021 When the inactivity counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse entry_error, clear the buffer and return to IDLE.
REQ-022 The inactivity counter SHALL be wide enough for TIMEOUT_CYCLES ($clog2) and SHALL never wrap.
REQ-023 PRESENT SHALL hold password_input stable.
REQ-024 PRESENT SHALL return to IDLE on sensor_vehicule falling, and password_input SHALL then be held until the next successful ENTER.
REQ-025 PRESENT SHALL treat a digit key as a new entry: buffer restarted with that digit, digit_count=1, state COLLECT.
REQ-026 A sensor_vehicule fall during COLLECT SHALL abort to IDLE with the buffer cleared and no pulse.
REQ-027 alarm_blocked=1 SHALL force LOCKED from any state, with the buffer cleared, digit_count=0 and keys ignored.
REQ-028 alarm_blocked=1 SHALL take priority over any key presented in the same cycle.
REQ-029 LOCKED SHALL exit to IDLE the first cycle alarm_blocked=0.
REQ-030 password_valid and entry_error SHALL never be asserted in the same cycle.
REQ-031 password_valid and entry_error SHALL each be registered, with no combinational path from inputs.

Reset
REQ-032 Assertion of rst (low) SHALL immediately force state IDLE.
REQ-033 Assertion of rst SHALL immediately set password_input=16'h0000, password_valid=0, entry_error=0, digit_count=0, and clear the buffer and the inactivity counter.
REQ-034 Reset assertion mid-entry SHALL discard all buffered digits.
REQ-035 After rst deasserts, the first key SHALL be accepted no earlier than the following clock edge.

Structure
REQ-036 A shared package SHALL hold the state encoding, the key-code constants (KEY_CLEAR=4'hA, KEY_ENTER=4'hB) and the PIN width of 16.
REQ-037 One sub-module, teclado_timeout, SHALL implement the inactivity counter.
REQ-038 teclado_timeout SHALL have inputs clear and enable and output expired.

Verification
REQ-039 Vehicle present; keys 3,7,6,1,ENTER -> single password_valid pulse with password_input=16'h3761, digit_count=4 on the ENTER cycle.
REQ-040 Keys 3,7,ENTER -> entry_error pulse, password_valid stays 0, digit_count returns to 0.
REQ-041 Keys 3,7,CLEAR,1,2,3,4,5,ENTER -> password_input=16'h1234, with digit 5 ignored.
REQ-042 Keys 3,7 then TIMEOUT_CYCLES idle cycles -> entry_error pulse and state IDLE.
REQ-043 alarm_blocked=1 in the same cycle as an ENTER after four digits -> no password_valid and state LOCKED.
REQ-043 (cont.) After alarm_blocked releases, keys 3,7,6,1,ENTER -> 16'h3761.
REQ-044 rst low after digits 3,7 -> all outputs 0.
REQ-044 (cont.) With sensor_vehicule=0, keys SHALL be ignored.

Source files
------------

// File: rtl/teclado_clave_pkg.sv
// Shared definitions for the parking keypad entry: FSM states, key codes, PIN width.
package teclado_clave_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam int unsigned PIN_W = 16;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/teclado_clave_timeout.sv
// Inactivity counter: counts enabled cycles since the last clear and
// saturates at TIMEOUT_CYCLES-1, flagging expiry there.
module teclado_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/teclado_clave.sv
// Four-digit keypad PIN entry with CLEAR/ENTER handling, inactivity timeout,
// vehicle-presence gating and alarm lockout.
module teclado_clave
  import teclado_clave_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             sensor_vehicule,
  input  logic             alarm_blocked,
  output logic [PIN_W-1:0] password_input,
  output logic             password_valid,
  output logic             entry_error,
  output logic [2:0]       digit_count
);

  state_t           state;
  logic [PIN_W-1:0] pin_buf;
  logic             key_digit;
  logic             key_accept;
  logic             to_clear;
  logic             to_enable;
  logic             to_expired;

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_accept = (key_digit && (digit_count < 3'd4)) ||
                      (key_valid && ((key_code == KEY_CLEAR) || (key_code == KEY_ENTER)));

  assign to_enable = (state == COLLECT);
  assign to_clear  = (state != COLLECT) || key_accept;

  teclado_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pin_buf        <= '0;
      digit_count    <= '0;
      password_input <= '0;
      password_valid <= 1'b0;
      entry_error    <= 1'b0;
    end else begin
      password_valid <= 1'b0;
      entry_error    <= 1'b0;
      if (alarm_blocked) begin
        state       <= LOCKED;
        pin_buf     <= '0;
        digit_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (key_digit && sensor_vehicule) begin
              pin_buf     <= {{(PIN_W-4){1'b0}}, key_code};
              digit_count <= 3'd1;
              state       <= COLLECT;
            end
          end
          COLLECT: begin
            if (!sensor_vehicule) begin
              pin_buf     <= '0;
              digit_count <= '0;
              state       <= IDLE;
            end else if (key_digit && (digit_count < 3'd4)) begin
              pin_buf     <= {pin_buf[PIN_W-5:0], key_code};
              digit_count <= digit_count + 3'd1;
            end else if (key_valid && (key_code == KEY_CLEAR)) begin
              pin_buf     <= '0;
              digit_count <= '0;
              state       <= IDLE;
            end else if (key_valid && (key_code == KEY_ENTER)) begin
              if (digit_count == 3'd4) begin
                password_input <= pin_buf;
                password_valid <= 1'b1;
                state          <= PRESENT;
              end else begin
                entry_error <= 1'b1;
                pin_buf     <= '0;
                digit_count <= '0;
                state       <= IDLE;
              end
            end else if (to_expired) begin
              // Ignored keys fall through here so they cannot stave off the timeout.
              entry_error <= 1'b1;
              pin_buf     <= '0;
              digit_count <= '0;
              state       <= IDLE;
            end
          end
          PRESENT: begin
            if (!sensor_vehicule) begin
              pin_buf     <= '0;
              digit_count <= '0;
              state       <= IDLE;
            end else if (key_digit) begin
              pin_buf     <= {{(PIN_W-4){1'b0}}, key_code};
              digit_count <= 3'd1;
              state       <= COLLECT;
            end
          end
          LOCKED: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_teclado_clave.sv
// Directed bench for teclado_clave: a table of key sequences plus hand-written
// reset, timeout, alarm and vehicle-presence sequences.
module tb_teclado_clave;
  import teclado_clave_pkg::*;

  localparam int unsigned TO = 20;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        sensor_vehicule;
  logic        alarm_blocked;
  logic [15:0] password_input;
  logic        password_valid;
  logic        entry_error;
  logic [2:0]  digit_count;

  int total;
  int bad;
  int vcnt;
  int ecnt;

  teclado_clave #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .sensor_vehicule(sensor_vehicule),
    .alarm_blocked  (alarm_blocked),
    .password_input (password_input),
    .password_valid (password_valid),
    .entry_error    (entry_error),
    .digit_count    (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (password_valid) vcnt++;
      if (entry_error) ecnt++;
      if (password_valid && entry_error) begin
        bad++;
        $display("FAIL pulse_exclusive: valid=1 error=1 at %0t, required not both", $time);
      end
    end
  end

  typedef struct {
    logic [39:0] keys;
    int          len;
    logic [15:0] pw;
    int          nv;
    int          ne;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    rst  = 1'b1;
    vcnt = 0;
    ecnt = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int found;
    logic [39:0] kk;

    total = 0; bad = 0; vcnt = 0; ecnt = 0;
    rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    sensor_vehicule = 1'b1; alarm_blocked = 1'b0;

    vecs[0] = '{keys: 40'h37_61B0_0000, len: 5, pw: 16'h3761, nv: 1, ne: 0, cnt: 3'd4};
    vecs[1] = '{keys: 40'h37_B000_0000, len: 3, pw: 16'h0000, nv: 0, ne: 1, cnt: 3'd0};
    vecs[2] = '{keys: 40'h37_A123_45B0, len: 9, pw: 16'h1234, nv: 1, ne: 0, cnt: 3'd4};
    vecs[3] = '{keys: 40'h90_09B0_0000, len: 5, pw: 16'h9009, nv: 1, ne: 0, cnt: 3'd4};
    vecs[4] = '{keys: 40'hBA_3CF1_24B0, len: 9, pw: 16'h3124, nv: 1, ne: 0, cnt: 3'd4};
    vecs[5] = '{keys: 40'h12_34B5_6000, len: 7, pw: 16'h1234, nv: 1, ne: 0, cnt: 3'd2};
    vecs[6] = '{keys: 40'h12_3A00_0000, len: 4, pw: 16'h0000, nv: 0, ne: 0, cnt: 3'd0};

    idle(2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_pw", 32'(password_input), 32'h0);
    check("reset_cnt", 32'(digit_count), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));

    for (int v = 0; v < 7; v++) begin
      do_reset();
      kk = vecs[v].keys;
      for (int i = 0; i < vecs[v].len; i++) begin
        press(kk[39:36]);
        kk = kk << 4;
      end
      idle(2);
      check($sformatf("vec%0d_pw", v), 32'(password_input), 32'(vecs[v].pw));
      check($sformatf("vec%0d_valid", v), 32'(vcnt), 32'(vecs[v].nv));
      check($sformatf("vec%0d_error", v), 32'(ecnt), 32'(vecs[v].ne));
      check($sformatf("vec%0d_cnt", v), 32'(digit_count), 32'(vecs[v].cnt));
    end

    // digit_count on the ENTER cycle, then async reset clears a held PIN and a partial entry
    do_reset();
    press(4'h3); press(4'h7); press(4'h6); press(4'h1);
    check("enter_cycle_cnt", 32'(digit_count), 32'd4);
    press(KEY_ENTER);
    check("enter_pw", 32'(password_input), 32'h3761);
    press(4'h3); press(4'h7);
    check("partial_cnt", 32'(digit_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_pw", 32'(password_input), 32'h0);
    check("async_rst_cnt", 32'(digit_count), 32'd0);
    check("async_rst_pulses", 32'({password_valid, entry_error}), 32'd0);
    check("async_rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1; vcnt = 0; ecnt = 0;
    press(KEY_ENTER);
    check("post_rst_no_valid", 32'(vcnt), 32'd0);

    // inactivity timeout after two digits
    do_reset();
    press(4'h3); press(4'h7);
    found = -1;
    for (int k = 0; k < 3 * TO; k++) begin
      if (found < 0 && entry_error) found = k + 1;
      @(posedge clk);
      #1;
    end
    if (found < 0) begin
      bad++; total++;
      $display("FAIL timeout_seen: no entry_error within %0d cycles, required one", 3 * TO);
    end else begin
      total++;
      if (found < int'(TO) - 1 || found > int'(TO) + 1) begin
        bad++;
        $display("FAIL timeout_latency: got %0d cycles, required about %0d", found, TO);
      end
    end
    check("timeout_err_count", 32'(ecnt), 32'd1);
    check("timeout_valid", 32'(vcnt), 32'd0);
    check("timeout_state", 32'(dut.state), 32'(IDLE));
    check("timeout_cnt", 32'(digit_count), 32'd0);

    // alarm beats an ENTER in the same cycle, keys ignored while locked
    do_reset();
    press(4'h3); press(4'h7); press(4'h6); press(4'h1);
    alarm_blocked = 1'b1;
    press(KEY_ENTER);
    check("alarm_state", 32'(dut.state), 32'(LOCKED));
    check("alarm_cnt", 32'(digit_count), 32'd0);
    press(4'h5);
    check("locked_key_cnt", 32'(digit_count), 32'd0);
    alarm_blocked = 1'b0;
    idle(1);
    check("unlock_state", 32'(dut.state), 32'(IDLE));
    check("alarm_no_valid", 32'(vcnt), 32'd0);
    press(4'h3); press(4'h7); press(4'h6); press(4'h1); press(KEY_ENTER);
    check("unlock_pw", 32'(password_input), 32'h3761);
    check("unlock_valid", 32'(vcnt), 32'd1);

    // no vehicle: keys ignored, held PIN kept
    sensor_vehicule = 1'b0;
    idle(1);
    check("present_fall_state", 32'(dut.state), 32'(IDLE));
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(KEY_ENTER);
    check("nosensor_cnt", 32'(digit_count), 32'd0);
    check("nosensor_pw", 32'(password_input), 32'h3761);
    check("nosensor_pulses", 32'(vcnt + ecnt), 32'd1);

    // vehicle leaves mid-entry: silent abort
    sensor_vehicule = 1'b1;
    press(4'h1); press(4'h2);
    sensor_vehicule = 1'b0;
    idle(1);
    check("collect_fall_cnt", 32'(digit_count), 32'd0);
    check("collect_fall_err", 32'(ecnt), 32'd0);
    sensor_vehicule = 1'b1;
    press(4'h3); press(4'h4); press(4'h5); press(4'h6); press(KEY_ENTER);
    check("after_abort_pw", 32'(password_input), 32'h3456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
